// File: rtl/mips_dbg_pkg.sv
// Shared types and command codes for the MIPS debug programming link.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_BYTES   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RUN_RST = 3'd4,
        ST_RUN     = 3'd5
    } loader_state_t;

    localparam logic [7:0] CMD_LOAD = 8'hA5;
    localparam logic [7:0] CMD_RUN  = 8'h3C;

endpackage

// File: rtl/loader_timeout_cnt.sv
// Down-counter with clear, load and terminal-count flag.
// tc is high while the count is zero; the count saturates at zero.
module loader_timeout_cnt #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Count down toward the terminal value; load has priority over dec.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/mips_prog_loader.sv
// Byte-stream program loader and run sequencer for the MIPS debug port.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for a command byte
// ST_LEN     | waiting for the word-count byte of a LOAD frame
// ST_BYTES   | assembling the current word, MSB byte first
// ST_WRITE   | one-cycle write strobe to instruction memory is out
// ST_RUN_RST | core held in reset with prog_mode=1
// ST_RUN     | core running; only a new LOAD is honoured
module mips_prog_loader
    import mips_dbg_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int RST_CYCLES  = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              cpu_reset,
    output logic              prog_mode,
    output logic [ADDR_W-1:0] addr_prog,
    output logic [DATA_W-1:0] data_prog,
    output logic              prog_we,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int NBYTES    = DATA_W / 8;
    localparam int BCNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int LEN_W     = ADDR_W + 1;
    localparam int WORDS_MAX = 1 << ADDR_W;
    localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int RST_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    loader_state_t     state;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] word_nxt;
    logic [BCNT_W-1:0] byte_cnt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  widx;
    logic [RST_W-1:0]  rst_cnt;
    logic              xfer;
    logic              tmo_active;
    logic              tmo_tc;

    assign xfer       = rx_valid & rx_ready;
    assign word_nxt   = (word << 8) | DATA_W'(rx_data);
    assign tmo_active = (state == ST_LEN) || (state == ST_BYTES);

    // Idle-gap timer: reloaded on every byte and whenever not waiting on the link,
    // so it only runs down across silence inside a frame.
    loader_timeout_cnt #(.W(TMO_W)) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .clr      (1'b0),
        .load     (xfer || !tmo_active),
        .dec      (tmo_active && !xfer),
        .load_val (TMO_W'(TIMEOUT_CYC - 1)),
        .tc       (tmo_tc)
    );

    // Frame decode, word assembly, write strobe and run-entry sequencing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            rx_ready     <= 1'b0;
            cpu_reset    <= 1'b1;
            prog_mode    <= 1'b0;
            addr_prog    <= '0;
            data_prog    <= '0;
            prog_we      <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            word         <= '0;
            byte_cnt     <= '0;
            len          <= '0;
            widx         <= '0;
            rst_cnt      <= '0;
        end else begin
            prog_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rx_ready <= 1'b1;
                    if (xfer) begin
                        if (rx_data == CMD_LOAD) begin
                            state     <= ST_LEN;
                            cpu_reset <= 1'b1;
                            prog_mode <= 1'b0;
                            widx      <= '0;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                        end else if (rx_data == CMD_RUN) begin
                            state     <= ST_RUN_RST;
                            cpu_reset <= 1'b1;
                            prog_mode <= 1'b1;
                            rx_ready  <= 1'b0;
                            busy      <= 1'b1;
                            err       <= 1'b0;
                            rst_cnt   <= RST_W'(RST_CYCLES - 1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_LEN: begin
                    if (xfer) begin
                        // An 8-bit length of zero can only mean a full 256-word image.
                        if ((ADDR_W == 8) && (rx_data == 8'd0)) begin
                            len      <= LEN_W'(WORDS_MAX);
                            byte_cnt <= '0;
                            state    <= ST_BYTES;
                        end else if ((rx_data == 8'd0) || (int'(rx_data) > WORDS_MAX)) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            len      <= LEN_W'(rx_data);
                            byte_cnt <= '0;
                            state    <= ST_BYTES;
                        end
                    end else if (tmo_tc) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_BYTES: begin
                    if (xfer) begin
                        word <= word_nxt;
                        if (byte_cnt == BCNT_W'(NBYTES - 1)) begin
                            // Strobe goes out with the state change so it lands
                            // the cycle right after the final byte.
                            byte_cnt  <= '0;
                            addr_prog <= widx[ADDR_W-1:0];
                            data_prog <= word_nxt;
                            prog_we   <= 1'b1;
                            widx      <= widx + LEN_W'(1);
                            rx_ready  <= 1'b0;
                            state     <= ST_WRITE;
                        end else begin
                            byte_cnt <= byte_cnt + BCNT_W'(1);
                        end
                    end else if (tmo_tc) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    rx_ready <= 1'b1;
                    if (widx == len) begin
                        words_loaded <= len;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end else begin
                        state <= ST_BYTES;
                    end
                end
                ST_RUN_RST: begin
                    if (rst_cnt == '0) begin
                        cpu_reset <= 1'b0;
                        rx_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_RUN;
                    end else begin
                        rst_cnt <= rst_cnt - RST_W'(1);
                    end
                end
                ST_RUN: begin
                    rx_ready <= 1'b1;
                    if (xfer && (rx_data == CMD_LOAD)) begin
                        state     <= ST_LEN;
                        cpu_reset <= 1'b1;
                        prog_mode <= 1'b0;
                        widx      <= '0;
                        busy      <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader: scoreboard of expected writes,
// directed checks on reset, run entry, timeout, bad command and mid-frame reset.
module tb_mips_prog_loader;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 32;
    localparam int RST_CYCLES  = 2;
    localparam int TIMEOUT_CYC = 50;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              cpu_reset;
    logic              prog_mode;
    logic [ADDR_W-1:0] addr_prog;
    logic [DATA_W-1:0] data_prog;
    logic              prog_we;
    logic              busy;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_we    = 0;
    wr_t  exp_q[$];
    logic [31:0] prog_words [2];

    mips_prog_loader #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RST_CYCLES  (RST_CYCLES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .cpu_reset    (cpu_reset),
        .prog_mode    (prog_mode),
        .addr_prog    (addr_prog),
        .data_prog    (data_prog),
        .prog_we      (prog_we),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && prog_we) begin
            n_we++;
            check_val("ready_in_write", 64'(rx_ready), 64'd0);
            if (exp_q.size() == 0) begin
                check_val("spurious_we", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_val("wr_addr", 64'(addr_prog), 64'(e.addr));
                check_val("wr_data", 64'(data_prog), 64'(e.data));
            end
        end
    end

    // Present a byte at a negedge and return at the negedge after it is taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited;
        if (gaps) begin
            int idle;
            idle = int'($urandom_range(0, 3));
            for (int i = 0; i < idle; i++) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            check_val("ready_wait_expired", 64'd0, 64'd1);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load_words(input int n, input bit gaps);
        send_byte(8'hA5, gaps);
        check_val("load_cpu_reset", 64'(cpu_reset), 64'd1);
        check_val("load_prog_mode", 64'(prog_mode), 64'd0);
        check_val("load_busy", 64'(busy), 64'd1);
        check_val("load_err", 64'(err), 64'd0);
        send_byte(8'(n), gaps);
        for (int i = 0; i < n; i++) begin
            logic [31:0] w;
            w = prog_words[i];
            exp_q.push_back('{addr: ADDR_W'(i), data: w});
            for (int k = 0; k < 4; k++) begin
                send_byte(w[31-8*k -: 8], gaps);
            end
            check_val("we_latency", 64'(prog_we), 64'd1);
        end
        @(negedge clk);
        check_val("busy_done", 64'(busy), 64'd0);
        check_val("words_loaded", 64'(words_loaded), 64'(n));
        check_val("idle_ready", 64'(rx_ready), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        check_val({tag, "_prog_mode"}, 64'(prog_mode), 64'd0);
        check_val({tag, "_prog_we"}, 64'(prog_we), 64'd0);
        check_val({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        check_val({tag, "_err"}, 64'(err), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_addr"}, 64'(addr_prog), 64'd0);
        check_val({tag, "_data"}, 64'(data_prog), 64'd0);
        check_val({tag, "_words"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        prog_words[0] = 32'h10600DDE;
        prog_words[1] = 32'hF8000004;
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back load of two words.
        load_words(2, 1'b0);
        check_val("sb_empty_1", 64'(exp_q.size()), 64'd0);

        // Run entry: exactly RST_CYCLES cycles of reset with prog_mode=1.
        send_byte(8'h3C, 1'b0);
        check_val("run_rst1_cpu_reset", 64'(cpu_reset), 64'd1);
        check_val("run_rst1_prog_mode", 64'(prog_mode), 64'd1);
        check_val("run_rst1_ready", 64'(rx_ready), 64'd0);
        check_val("run_rst1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check_val("run_rst2_cpu_reset", 64'(cpu_reset), 64'd1);
        check_val("run_rst2_prog_mode", 64'(prog_mode), 64'd1);
        @(negedge clk);
        check_val("run_cpu_reset", 64'(cpu_reset), 64'd0);
        check_val("run_prog_mode", 64'(prog_mode), 64'd1);
        check_val("run_busy", 64'(busy), 64'd0);
        check_val("run_ready", 64'(rx_ready), 64'd1);

        // Foreign bytes in RUN are dropped silently.
        send_byte(8'h55, 1'b0);
        check_val("run_drop_err", 64'(err), 64'd0);
        check_val("run_drop_cpu_reset", 64'(cpu_reset), 64'd0);

        // Reload from RUN with random gaps on rx_valid.
        load_words(2, 1'b1);
        check_val("sb_empty_2", 64'(exp_q.size()), 64'd0);

        // Timeout: frame stalls after one data byte.
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        repeat (TIMEOUT_CYC - 5) @(negedge clk);
        check_val("tmo_early_err", 64'(err), 64'd0);
        check_val("tmo_early_busy", 64'(busy), 64'd1);
        repeat (6) @(negedge clk);
        check_val("tmo_err", 64'(err), 64'd1);
        check_val("tmo_busy", 64'(busy), 64'd0);
        check_val("tmo_ready", 64'(rx_ready), 64'd1);
        check_val("tmo_cpu_reset", 64'(cpu_reset), 64'd1);
        check_val("tmo_prog_mode", 64'(prog_mode), 64'd0);
        check_val("tmo_we_count", 64'(n_we), 64'd4);
        send_byte(8'hA5, 1'b0);
        check_val("tmo_err_cleared", 64'(err), 64'd0);

        // Reset out of LEN, then a bad command.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_byte(8'h77, 1'b0);
        check_val("bad_cmd_err", 64'(err), 64'd1);
        check_val("bad_cmd_busy", 64'(busy), 64'd0);

        // Mid-frame reset: no strobe, everything back to reset values.
        send_byte(8'hA5, 1'b0);
        check_val("bad_cmd_err_cleared", 64'(err), 64'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check_val("final_we_count", 64'(n_we), 64'd4);
        check_val("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
